// File: rtl/scrub_scheduler.sv
// ---------------------------------------------------------------------------
// scrub_scheduler
//
// Purpose:
//   Multi-region configuration-scrub scheduler. It arbitrates two kinds of work
//   across NUM_REGIONS configuration regions:
//     - periodic round-robin scrubs, one every PERIOD_CYCLES cycles
//     - urgent scrubs triggered by SEFI strobes (lowest region index first)
//   It issues requests to the frame readback / DPR engine over valid/ready and
//   retries failed scrubs. After MAX_RETRY retries it escalates to a full
//   partial reconfiguration. A region whose DPR attempt also fails is flagged
//   in fault_map.
//
// Optional build macro:
//   SCRUB_STATS_EN - adds saturating statistics outputs scrub_count,
//                    err_count and escalate_count.
//
// Ports:
//   clk             system clock
//   rst             synchronous, active-high reset
//   enable          scheduler enable; low holds the period timer at 0 and
//                   blocks new issues (an in-flight scrub still completes)
//   sefi_detected   single-cycle SEFI strobe
//   sefi_region     region index for sefi_detected
//   req_valid       scrub request valid
//   req_ready       engine accepts the request
//   req_region      region to scrub
//   req_mode        0 = frame readback scrub, 1 = full DPR reconfiguration
//   done_valid      engine completion strobe
//   done_err        completion carried an error (qualified by done_valid)
//   scrub_active    high from request acceptance until completion
//   fault_map       sticky per-region flag: region failed DPR escalation
//   period_overrun  sticky: period expired while a periodic scrub was pending
//   scrub_count     (SCRUB_STATS_EN) successful completions, saturating
//   err_count       (SCRUB_STATS_EN) error completions plus timeouts, saturating
//   escalate_count  (SCRUB_STATS_EN) DPR escalations, saturating
//
// All outputs come straight from registers. No input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module scrub_scheduler #(
    parameter int NUM_REGIONS    = 4,
    parameter int REGION_W       = $clog2(NUM_REGIONS),
    parameter int PERIOD_CYCLES  = 50_000_000,
    parameter int TIMER_W        = 32,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_RETRY      = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   sefi_detected,
    input  logic [REGION_W-1:0]    sefi_region,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [REGION_W-1:0]    req_region,
    output logic                   req_mode,
    input  logic                   done_valid,
    input  logic                   done_err,
    output logic                   scrub_active,
    output logic [NUM_REGIONS-1:0] fault_map,
`ifdef SCRUB_STATS_EN
    output logic [15:0]            scrub_count,
    output logic [15:0]            err_count,
    output logic [7:0]             escalate_count,
`endif
    output logic                   period_overrun
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [TIMER_W-1:0]  TIMER_LAST   = TIMER_W'(PERIOD_CYCLES - 1);
    localparam logic [TO_W-1:0]     TO_LAST      = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REGION_W-1:0] LAST_REGION  = REGION_W'(NUM_REGIONS - 1);
    localparam logic [REGION_W:0]   REGION_LIMIT = (REGION_W + 1)'(NUM_REGIONS);
    localparam logic [2:0]          RETRY_LIMIT  = 3'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [TIMER_W-1:0]     timer;
    logic [REGION_W-1:0]    rr_ptr;
    logic [NUM_REGIONS-1:0] sefi_pend;
    logic [NUM_REGIONS-1:0] sefi_next;
    logic                   per_pend;
    logic [2:0]             retry;
    logic [TO_W-1:0]        wait_cnt;
    logic                   src_sefi;
    logic [REGION_W-1:0]    req_region_q;
    logic                   req_mode_q;
    logic [NUM_REGIONS-1:0] fault_map_q;
    logic                   overrun_q;

    logic [REGION_W-1:0]    sefi_idx;
    logic                   any_sefi;
    logic                   timer_tc;
    logic                   sefi_ok;
    logic                   per_clr;

    logic                   start;
    logic                   handshake;
    logic                   success;
    logic                   err;
    logic                   retry_again;
    logic                   escalate;
    logic                   fault;
    logic                   finish;

    assign any_sefi = |sefi_pend;
    assign timer_tc = enable && (timer == TIMER_LAST);
    // Strobes that name a region this instance does not have are dropped.
    assign sefi_ok  = sefi_detected && ({1'b0, sefi_region} < REGION_LIMIT);
    assign finish   = success | fault;
    // Completion of a periodic scrub frees the periodic slot and moves the pointer.
    assign per_clr  = finish && !src_sefi;

    // Lowest pending SEFI index. The loop runs downward so the lowest set bit
    // is the last assignment and wins.
    always_comb begin
        sefi_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (sefi_pend[i]) begin
                sefi_idx = REGION_W'(i);
            end
        end
    end

    // A new strobe is applied after the completion clear, so a fresh SEFI on the
    // region that just finished is kept rather than lost.
    always_comb begin
        sefi_next = sefi_pend;
        if (finish && src_sefi) begin
            sefi_next[req_region_q] = 1'b0;
        end
        if (sefi_ok) begin
            sefi_next[sefi_region] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and single-cycle event strobes for the datapath.
    always_comb begin
        state_next  = state;
        start       = 1'b0;
        handshake   = 1'b0;
        success     = 1'b0;
        err         = 1'b0;
        retry_again = 1'b0;
        escalate    = 1'b0;
        fault       = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (any_sefi || per_pend)) begin
                    start      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (req_ready) begin
                    handshake  = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A clean completion takes priority over a timeout in the same cycle.
                if (done_valid && !done_err) begin
                    success    = 1'b1;
                    state_next = IDLE;
                end else if (done_valid || (wait_cnt == TO_LAST)) begin
                    err = 1'b1;
                    if (req_mode_q) begin
                        fault      = 1'b1;
                        state_next = IDLE;
                    end else if (retry < RETRY_LIMIT) begin
                        retry_again = 1'b1;
                        state_next  = ISSUE;
                    end else begin
                        escalate   = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer        <= '0;
            rr_ptr       <= '0;
            sefi_pend    <= '0;
            per_pend     <= 1'b0;
            retry        <= '0;
            wait_cnt     <= '0;
            src_sefi     <= 1'b0;
            req_region_q <= '0;
            req_mode_q   <= 1'b0;
            fault_map_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            if (!enable || timer_tc) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            // At terminal count a still-pending periodic request is not doubled
            // up; it is reported as an overrun instead.
            if (timer_tc) begin
                if (per_pend && !per_clr) begin
                    overrun_q <= 1'b1;
                end else begin
                    per_pend <= 1'b1;
                end
            end else if (per_clr) begin
                per_pend <= 1'b0;
            end

            if (per_clr) begin
                rr_ptr <= (rr_ptr == LAST_REGION) ? '0 : rr_ptr + 1'b1;
            end

            sefi_pend <= sefi_next;

            if (start) begin
                req_region_q <= any_sefi ? sefi_idx : rr_ptr;
                src_sefi     <= any_sefi;
                req_mode_q   <= 1'b0;
                retry        <= '0;
            end

            if (retry_again) begin
                retry <= retry + 1'b1;
            end

            if (escalate) begin
                req_mode_q <= 1'b1;
            end

            if (handshake) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (fault) begin
                fault_map_q[req_region_q] <= 1'b1;
            end
        end
    end

`ifdef SCRUB_STATS_EN
    logic [15:0] scrub_cnt_q;
    logic [15:0] err_cnt_q;
    logic [7:0]  esc_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scrub_cnt_q <= '0;
            err_cnt_q   <= '0;
            esc_cnt_q   <= '0;
        end else begin
            if (success && (scrub_cnt_q != 16'hFFFF)) begin
                scrub_cnt_q <= scrub_cnt_q + 1'b1;
            end
            if (err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
            if (escalate && (esc_cnt_q != 8'hFF)) begin
                esc_cnt_q <= esc_cnt_q + 1'b1;
            end
        end
    end

    assign scrub_count    = scrub_cnt_q;
    assign err_count      = err_cnt_q;
    assign escalate_count = esc_cnt_q;
`endif

    assign req_valid      = (state == ISSUE);
    assign scrub_active   = (state == WAIT);
    assign req_region     = req_region_q;
    assign req_mode       = req_mode_q;
    assign fault_map      = fault_map_q;
    assign period_overrun = overrun_q;

endmodule

// File: tb/tb_scrub_scheduler.sv
// ---------------------------------------------------------------------------
// tb_scrub_scheduler
//
// Directed self-checking bench for scrub_scheduler with a short period
// (100 cycles), 4 regions, a 20-cycle timeout and MAX_RETRY=3. Inputs are
// driven and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_scrub_scheduler;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       sefi_detected;
    logic [1:0] sefi_region;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_region;
    logic       req_mode;
    logic       done_valid;
    logic       done_err;
    logic       scrub_active;
    logic [3:0] fault_map;
    logic       period_overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    scrub_scheduler #(
        .NUM_REGIONS   (4),
        .REGION_W      (2),
        .PERIOD_CYCLES (100),
        .TIMER_W       (32),
        .TIMEOUT_CYCLES(20),
        .MAX_RETRY     (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .sefi_detected (sefi_detected),
        .sefi_region   (sefi_region),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_region    (req_region),
        .req_mode      (req_mode),
        .done_valid    (done_valid),
        .done_err      (done_err),
        .scrub_active  (scrub_active),
        .fault_map     (fault_map),
        .period_overrun(period_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rising edges; an issue observed on the falling edge after rising
    // edge N reads cyc == N.
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset();
        rst           = 1'b1;
        enable        = 1'b0;
        req_ready     = 1'b0;
        done_valid    = 1'b0;
        done_err      = 1'b0;
        sefi_detected = 1'b0;
        sefi_region   = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_sefi(input logic [1:0] region);
        sefi_detected = 1'b1;
        sefi_region   = region;
        @(negedge clk);
        sefi_detected = 1'b0;
    endtask

    // Engine model: waits for a request, accepts it, holds the scrub for lat
    // cycles, then completes with the given error flag. It returns what it saw.
    task automatic engine_serve(input bit err, input int lat,
                                output logic [1:0] region, output logic mode,
                                output int issue_cyc, output int active,
                                output bit seen);
        seen      = 1'b0;
        active    = 0;
        region    = 2'bxx;
        mode      = 1'bx;
        issue_cyc = -1;
        req_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (req_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) return;
        region    = req_region;
        mode      = req_mode;
        issue_cyc = cyc;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (scrub_active === 1'b1) active++;
            if (i == lat) begin
                done_valid = 1'b1;
                done_err   = err;
            end
        end
        @(negedge clk);
        done_valid = 1'b0;
        done_err   = 1'b0;
        if (scrub_active === 1'b1) active++;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        enable        = 1'b1;
        req_ready     = 1'b1;
        done_valid    = 1'b0;
        done_err      = 1'b0;
        sefi_detected = 1'b0;
        sefi_region   = 2'd0;
        repeat (3) @(negedge clk);
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_valid: got %b expected 0", req_valid); end
        n_checks++; if (req_region !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_req_region: got %0d expected 0", req_region); end
        n_checks++; if (req_mode !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_mode: got %b expected 0", req_mode); end
        n_checks++; if (scrub_active !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_scrub_active: got %b expected 0", scrub_active); end
        n_checks++; if (fault_map !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_fault_map: got %b expected 0000", fault_map); end
        n_checks++; if (period_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overrun: got %b expected 0", period_overrun); end
    endtask

    task automatic test_periodic();
        logic [1:0] region;
        logic       mode;
        int         issue_cyc, active, prev_cyc, c0;
        bit         seen;
        logic [1:0] exp_region [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        enable   = 1'b1;
        c0       = cyc;
        prev_cyc = c0;
        for (int k = 0; k < 5; k++) begin
            engine_serve(1'b0, 5, region, mode, issue_cyc, active, seen);
            n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL periodic_seen[%0d]: no request within bound", k); end
            n_checks++; if (region !== exp_region[k]) begin n_fail++; $display("[TB] FAIL periodic_region[%0d]: got %0d expected %0d", k, region, exp_region[k]); end
            n_checks++; if (mode !== 1'b0) begin n_fail++; $display("[TB] FAIL periodic_mode[%0d]: got %b expected 0", k, mode); end
            n_checks++; if (active != 5) begin n_fail++; $display("[TB] FAIL periodic_active[%0d]: got %0d cycles expected 5", k, active); end
            // First issue follows the terminal count (edge 100) by one cycle.
            n_checks++;
            if ((issue_cyc - prev_cyc) != ((k == 0) ? 101 : 100)) begin
                n_fail++;
                $display("[TB] FAIL periodic_spacing[%0d]: got %0d expected %0d", k, issue_cyc - prev_cyc, (k == 0) ? 101 : 100);
            end
            prev_cyc = issue_cyc;
        end
        n_checks++; if (period_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL periodic_overrun: got %b expected 0", period_overrun); end
    endtask

    task automatic test_sefi_priority();
        logic [1:0] region;
        logic       mode;
        int         issue_cyc, active, extra;
        bit         seen;
        logic [1:0] exp_region [3] = '{2'd1, 2'd2, 2'd0};
        do_reset();
        pulse_sefi(2'd2);
        pulse_sefi(2'd1);
        repeat (3) @(negedge clk);
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sefi_disabled_issue: got %b expected 0", req_valid); end
        // Enable with the engine stalled so the region 2 repeat strobe lands on
        // the timer terminal count (edge 100 after enable).
        enable = 1'b1;
        repeat (99) @(negedge clk);
        n_checks++; if (req_region !== 2'd1) begin n_fail++; $display("[TB] FAIL sefi_first_winner: got %0d expected 1", req_region); end
        pulse_sefi(2'd2);
        n_checks++; if (period_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL sefi_overrun: got %b expected 0", period_overrun); end
        for (int k = 0; k < 3; k++) begin
            engine_serve(1'b0, 5, region, mode, issue_cyc, active, seen);
            n_checks++; if (region !== exp_region[k]) begin n_fail++; $display("[TB] FAIL sefi_order[%0d]: got %0d expected %0d", k, region, exp_region[k]); end
            n_checks++; if (mode !== 1'b0) begin n_fail++; $display("[TB] FAIL sefi_mode[%0d]: got %b expected 0", k, mode); end
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_valid !== 1'b0) extra++;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("[TB] FAIL sefi_merge_extra: got %0d request cycles expected 0", extra); end
    endtask

    task automatic test_retry_escalation();
        logic [1:0] region;
        logic       mode;
        int         issue_cyc, active, extra;
        bit         seen;
        do_reset();
        pulse_sefi(2'd3);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            engine_serve(1'b1, 5, region, mode, issue_cyc, active, seen);
            n_checks++; if (region !== 2'd3) begin n_fail++; $display("[TB] FAIL retry_region[%0d]: got %0d expected 3", k, region); end
            n_checks++; if (mode !== 1'b0) begin n_fail++; $display("[TB] FAIL retry_mode[%0d]: got %b expected 0", k, mode); end
        end
        n_checks++; if (fault_map !== 4'b0000) begin n_fail++; $display("[TB] FAIL retry_fault_early: got %b expected 0000", fault_map); end
        engine_serve(1'b1, 5, region, mode, issue_cyc, active, seen);
        n_checks++; if (region !== 2'd3) begin n_fail++; $display("[TB] FAIL escalate_region: got %0d expected 3", region); end
        n_checks++; if (mode !== 1'b1) begin n_fail++; $display("[TB] FAIL escalate_mode: got %b expected 1", mode); end
        n_checks++; if (fault_map !== 4'b1000) begin n_fail++; $display("[TB] FAIL escalate_fault_map: got %b expected 1000", fault_map); end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_valid !== 1'b0 || scrub_active !== 1'b0) extra++;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("[TB] FAIL escalate_idle: got %0d busy cycles expected 0", extra); end
    endtask

    task automatic test_timeout();
        logic [1:0] region;
        logic       mode;
        int         issue_cyc, active, act_to;
        bit         seen, got_req;
        do_reset();
        pulse_sefi(2'd1);
        enable    = 1'b1;
        req_ready = 1'b1;
        got_req   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (req_valid === 1'b1) begin
                got_req = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++; if (!got_req) begin n_fail++; $display("[TB] FAIL timeout_first_req: no request within bound"); end
        act_to = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (scrub_active === 1'b1) act_to++;
            else break;
        end
        n_checks++; if (act_to != 20) begin n_fail++; $display("[TB] FAIL timeout_wait_len: got %0d cycles expected 20", act_to); end
        n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_retry_valid: got %b expected 1", req_valid); end
        n_checks++; if (req_region !== 2'd1) begin n_fail++; $display("[TB] FAIL timeout_retry_region: got %0d expected 1", req_region); end
        engine_serve(1'b0, 5, region, mode, issue_cyc, active, seen);
        n_checks++; if (region !== 2'd1 || mode !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_retry_req: got region %0d mode %b expected region 1 mode 0", region, mode); end
        n_checks++; if (active != 5) begin n_fail++; $display("[TB] FAIL timeout_retry_active: got %0d expected 5", active); end
    endtask

    task automatic test_backpressure();
        logic [1:0] region;
        logic       mode;
        int         issue_cyc, active, unstable;
        bit         got_req, seen;
        do_reset();
        enable  = 1'b1;
        got_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (req_valid === 1'b1) begin
                got_req = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++; if (!got_req) begin n_fail++; $display("[TB] FAIL bp_first_req: no request within bound"); end
        n_checks++; if (period_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_overrun_early: got %b expected 0", period_overrun); end
        unstable = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (req_valid !== 1'b1 || req_region !== 2'd0 || req_mode !== 1'b0 || scrub_active !== 1'b0) unstable++;
        end
        n_checks++; if (unstable != 0) begin n_fail++; $display("[TB] FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
        n_checks++; if (period_overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_overrun: got %b expected 1", period_overrun); end
        engine_serve(1'b0, 5, region, mode, issue_cyc, active, seen);
        n_checks++; if (region !== 2'd0) begin n_fail++; $display("[TB] FAIL bp_served_region: got %0d expected 0", region); end
        n_checks++; if (period_overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_overrun_sticky: got %b expected 1", period_overrun); end
    endtask

    task automatic test_reset_in_wait();
        logic [1:0] region;
        logic       mode;
        int         issue_cyc, active, c_rst;
        bit         seen;
        do_reset();
        pulse_sefi(2'd2);
        enable    = 1'b1;
        req_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (scrub_active !== 1'b1 || req_region !== 2'd2) begin n_fail++; $display("[TB] FAIL rstwait_pre: got active %b region %0d expected active 1 region 2", scrub_active, req_region); end
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        c_rst = cyc;
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstwait_req_valid: got %b expected 0", req_valid); end
        n_checks++; if (req_region !== 2'd0) begin n_fail++; $display("[TB] FAIL rstwait_req_region: got %0d expected 0", req_region); end
        n_checks++; if (req_mode !== 1'b0) begin n_fail++; $display("[TB] FAIL rstwait_req_mode: got %b expected 0", req_mode); end
        n_checks++; if (scrub_active !== 1'b0) begin n_fail++; $display("[TB] FAIL rstwait_scrub_active: got %b expected 0", scrub_active); end
        n_checks++; if (fault_map !== 4'b0000 || period_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL rstwait_sticky: got fault %b overrun %b expected 0000 0", fault_map, period_overrun); end
        engine_serve(1'b0, 5, region, mode, issue_cyc, active, seen);
        n_checks++; if (region !== 2'd0) begin n_fail++; $display("[TB] FAIL rstwait_next_region: got %0d expected 0", region); end
        n_checks++; if ((issue_cyc - c_rst) != 101) begin n_fail++; $display("[TB] FAIL rstwait_next_delay: got %0d expected 101", issue_cyc - c_rst); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_sefi_priority();
        test_retry_escalation();
        test_timeout();
        test_backpressure();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scrub_scheduler.md
Name: scrub_scheduler

Overview:
Parametrised multi-region configuration-scrub scheduler. It is the successor to the single-timer scrub and SEFI healers.
- Arbitrates periodic round-robin scrubs and SEFI-triggered urgent scrubs across NUM_REGIONS configuration regions.
- Issues requests over valid/ready to the frame readback / DPR engine.
- Retries failed scrubs, then escalates to full partial reconfiguration.
- Flags regions that cannot be healed.

Parameters:
- NUM_REGIONS, 4, number of configuration regions (2..16)
- REGION_W, $clog2(NUM_REGIONS), region index width
- PERIOD_CYCLES, 50_000_000, cycles between periodic scrubs (1 s at 50 MHz)
- TIMER_W, 32, period timer width; PERIOD_CYCLES must be < 2**TIMER_W
- TIMEOUT_CYCLES, 1_000_000, max cycles in WAIT before the attempt counts as an error
- MAX_RETRY, 3, readback-scrub retries before DPR escalation (1..7)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  scheduler enable
- sefi_detected  in  1  single-cycle SEFI strobe
- sefi_region  in  REGION_W  region for sefi_detected
- req_valid  out  1  scrub request valid
- req_ready  in  1  engine accepts request
- req_region  out  REGION_W  region to scrub
- req_mode  out  1  0 = frame readback scrub, 1 = full DPR reconfig
- done_valid  in  1  engine completion strobe
- done_err  in  1  completion carried an error (qualified by done_valid)
- scrub_active  out  1  high from request issue until completion
- fault_map  out  NUM_REGIONS  sticky: region failed DPR escalation
- period_overrun  out  1  sticky: period expired while a periodic scrub was still pending

Behaviour:
- Reset values:
  - outputs: req_valid=0, req_region=0, req_mode=0, scrub_active=0, fault_map=0, period_overrun=0
  - internal: timer=0, rr_ptr=0, sefi_pend=0, per_pend=0, retry=0, state=IDLE
- Reset mid-operation: all of the above apply on the next edge. req_valid may drop without a handshake; the engine tolerates this.
- Timer:
  - Counts 0..PERIOD_CYCLES-1 while enable=1, then wraps to 0.
  - At terminal count it sets per_pend.
  - If per_pend is already set at terminal count, period_overrun is set instead (no second pending request).
  - enable=0 holds the timer at 0 and blocks new issues. An in-flight scrub completes normally.
- SEFI capture:
  - sefi_detected sets sefi_pend[sefi_region] in any state.
  - A repeat strobe on an already-pending region merges with the existing request.
  - If sefi_region >= NUM_REGIONS, the strobe is ignored.
- Arbitration (IDLE, enable=1):
  - Any sefi_pend bit beats per_pend. Among SEFI bits, the lowest index wins.
  - Otherwise per_pend selects rr_ptr.
  - A SEFI strobe and a timer terminal count in the same cycle are both captured; SEFI is served first.
- FSM:
  - IDLE -> ISSUE: one cycle after a pending request is seen. The winner is latched into req_region, req_mode=0, retry=0.
  - ISSUE:
    - req_valid=1, with req_region and req_mode held stable until req_ready.
    - The handshake completes in the cycle req_valid & req_ready. Next state is WAIT; scrub_active=1 from that edge.
  - WAIT:
    - On done_valid & !done_err: success.
    - On done_valid & done_err, or on timeout counter == TIMEOUT_CYCLES-1: error.
    - done_valid outside WAIT is ignored.
  - Success, or final failure:
    - Clear the source pending bit: the SEFI bit, or per_pend with rr_ptr advanced modulo NUM_REGIONS.
    - scrub_active=0, go to IDLE.
  - Error with req_mode=0 and retry<MAX_RETRY: retry++, back to ISSUE with the same region.
  - Error with req_mode=0 and retry==MAX_RETRY: req_mode=1 (escalate), back to ISSUE.
  - Error with req_mode=1: set fault_map[req_region], treat as final failure.
- Faulted regions are still scrubbed. fault_map clears only on rst.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SCRUB_STATS_EN
- Defined:
  - Adds outputs scrub_count[15:0] (successful completions), err_count[15:0] (error completions plus timeouts) and escalate_count[7:0] (DPR escalations).
  - All three counters saturate and reset to 0.
- Undefined: these ports and counters do not exist.

Test Plan:
- Periodic round-robin: PERIOD_CYCLES=100, NUM_REGIONS=4, engine answers ready immediately and done_err=0 after 5 cycles -> req_region 0,1,2,3,0 issued on 100-cycle spacing; scrub_active high 5 cycles each.
- SEFI priority and merge: sefi strobes on region 2 then 1 while idle, plus region 2 again, then a timer expiry in the same cycle -> issue order 1, 2, then periodic; region 2 is scrubbed only once.
- Retry and escalation: MAX_RETRY=3 and region 3 always returns done_err=1 -> four mode-0 requests, one mode-1 request, then fault_map=4'b1000 and return to IDLE.
- Timeout: no done_valid for TIMEOUT_CYCLES -> counted as an error, retry issued with the same region.
- Backpressure and overrun: req_ready low for 250 cycles with PERIOD_CYCLES=100 -> req_valid, req_region and req_mode stable throughout; period_overrun=1.
- Reset in WAIT: rst pulse mid-scrub -> next cycle all outputs are at reset values, and the next request is region 0 after a full period.
